rom2ram_loader: RTL and testbench
=================================

// Module: rom2ram_loader
// PURPOSE
//  Boot-time copier: on an init pulse, reads WORDS consecutive words from a ROM port with variable latency.
//  Each word is written to a RAM port, from ROM_BASE to RAM_BASE.
//  Parametrised successor of the fixed 8-bit/17-bit ROM-to-RAM init block.
//  Sits between the flash/ROM reader and the SRAM arbiter; holds the CPU via init_busy until done.
// PARAMETERS
//  DATA_W    8        data width of ROM and RAM ports
//  ADDR_W    17       address width of both ports
//  WORDS     131072   words to copy; 1..2**ADDR_W
//  ROM_BASE  0        first ROM address; addresses wrap modulo 2**ADDR_W
//  RAM_BASE  0        first RAM address; addresses wrap modulo 2**ADDR_W
// PORTS
//  clock           in   1       system clock, all logic on rising edge
//  reset           in   1       asynchronous, active-high reset
//  init            in   1       start request, sampled in IDLE/DONE only
//  datain          in   DATA_W  ROM read data, valid while rom_data_ready=1
//  rom_data_ready  in   1       ROM read completion strobe
//  rom_address     out  ADDR_W  ROM read address
//  rom_rden        out  1       ROM read request, 1-cycle pulse per word
//  ram_address     out  ADDR_W  RAM write address
//  dataout         out  DATA_W  RAM write data
//  ram_wren        out  1       RAM write strobe, 1-cycle pulse per word
//  init_busy       out  1       1 from the cycle after init accept until copy completes
//  init_done       out  1       1-cycle pulse when last word has been written
//  checksum        out  DATA_W  mod-2**DATA_W sum of copied words; present only with ROM2RAM_CSUM_EN
// BEHAVIOUR
//  All outputs are registered.
//  Reset: state=IDLE, all strobes 0, init_busy=0, init_done=0, addresses=0, dataout=0, checksum=0, cnt=0.
//  Reset is honoured mid-copy: the copy is aborted, the FSM is in IDLE, and no further strobe is issued.
//  FSM states: IDLE, READ, WAIT, WRITE, DONE.
//   IDLE : init=1 -> rom_address=ROM_BASE, ram_address=RAM_BASE, cnt=0, init_busy=1 -> READ.
//   READ : rom_rden=1 for exactly this cycle -> WAIT.
//   WAIT : hold rom_address; when rom_data_ready=1, dataout<=datain -> WRITE.
//          rom_data_ready is ignored in every other state; no timeout.
//   WRITE: ram_wren=1 for one cycle with stable ram_address/dataout.
//          If cnt==WORDS-1 -> DONE.
//          Otherwise cnt++, rom_address++, ram_address++ (both wrap at 2**ADDR_W) -> READ.
//   DONE : init_done=1 for one cycle, init_busy=0 -> IDLE.
//  Throughput: minimum 3 cycles/word (READ, WAIT with immediate ready, WRITE).
//  Latency from init to first ram_wren: >=3 cycles.
//  init while busy (READ/WAIT/WRITE) is ignored; it does not restart the copy.
//  init held high continuously causes a new copy to start the cycle after DONE.
//  ram_address/dataout keep their last values after completion.
//  cnt is ADDR_W+1 bits wide, so WORDS=2**ADDR_W is legal.
//  WORDS=1: exactly one read and one write, then done.
//  rom_data_ready in the same cycle as rom_rden is not sampled; it must arrive from WAIT onward.
// CONFIGURATION
//  ROM2RAM_CSUM_EN defined:
//   - checksum is cleared on init accept.
//   - checksum += datain on every WAIT->WRITE transition, mod 2**DATA_W.
//   - checksum is valid and stable from the init_done pulse until the next init accept.
//  ROM2RAM_CSUM_EN undefined: checksum port and adder are absent; all other behaviour is identical.
// TESTING
//  T1 WORDS=4, ROM_BASE=0x10, RAM_BASE=0x200, ROM returns addr^0x5A, ready 1 cycle after rden:
//     -> 4 writes with RAM[0x200..0x203]=0x4A,0x4B,0x48,0x49; init_done at 12 cycles after accept;
//        init_busy high 12 cycles.
//  T2 Random ROM latency 1..7 cycles, WORDS=16:
//     -> exactly one rden and one wren per word, in order; no wren before the matching ready;
//        no data loss.
//  T3 ADDR_W=4, ROM_BASE=0xE, RAM_BASE=0xF, WORDS=3:
//     -> rom_address sequence 0xE,0xF,0x0; ram_address sequence 0xF,0x0,0x1.
//  T4 Assert reset during WAIT of word 2:
//     -> all strobes 0 immediately, init_busy=0; a fresh init copies from word 0 again.
//  T5 Pulse init during WRITE of word 1, and hold init high through DONE:
//     -> the mid-copy init is ignored; a second copy starts 1 cycle after the init_done pulse.
//  T6 ROM2RAM_CSUM_EN, WORDS=3, data 0xF0,0x20,0x05 -> checksum=0x15 at init_done;
//     rebuild without the macro: port absent, T1 passes unchanged.

Source files
------------

// File: rtl/rom2ram_if.sv
// rom2ram_if: ROM read / RAM write / init handshake bundle for rom2ram_loader; checksum present with ROM2RAM_CSUM_EN
interface rom2ram_if #(parameter int DATA_W = 8, parameter int ADDR_W = 17);
  logic              init;
  logic [DATA_W-1:0] datain;
  logic              rom_data_ready;
  logic [ADDR_W-1:0] rom_address;
  logic              rom_rden;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] dataout;
  logic              ram_wren;
  logic              init_busy;
  logic              init_done;
`ifdef ROM2RAM_CSUM_EN
  logic [DATA_W-1:0] checksum;
  modport master(input init, datain, rom_data_ready,
                 output rom_address, rom_rden, ram_address, dataout, ram_wren, init_busy, init_done, checksum);
  modport slave(output init, datain, rom_data_ready,
                input rom_address, rom_rden, ram_address, dataout, ram_wren, init_busy, init_done, checksum);
`else
  modport master(input init, datain, rom_data_ready,
                 output rom_address, rom_rden, ram_address, dataout, ram_wren, init_busy, init_done);
  modport slave(output init, datain, rom_data_ready,
                input rom_address, rom_rden, ram_address, dataout, ram_wren, init_busy, init_done);
`endif
endinterface

// File: rtl/rom2ram_loader.sv
// rom2ram_loader: boot-time copier of WORDS words from a variable-latency ROM into RAM.
// Optional running checksum of copied words is enabled by defining ROM2RAM_CSUM_EN.
module rom2ram_loader #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 17,
  parameter int WORDS    = 131072,
  parameter int ROM_BASE = 0,
  parameter int RAM_BASE = 0
) (
  input logic       clock,
  input logic       reset,
  rom2ram_if.master bus
);
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(WORDS - 1);
  logic [2:0]    state;
  logic [ADDR_W:0] cnt;
  logic          start;
  logic          last;
  assign start = bus.init && (state == IDLE || state == DONE);
  assign last  = cnt == LAST;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.rom_address <= '0;
      bus.ram_address <= '0;
      bus.dataout     <= '0;
      bus.rom_rden    <= 1'b0;
      bus.ram_wren    <= 1'b0;
      bus.init_busy   <= 1'b0;
      bus.init_done   <= 1'b0;
`ifdef ROM2RAM_CSUM_EN
      bus.checksum    <= '0;
`endif
    end else begin
      bus.rom_rden  <= start || (state == WRITE && !last);
      bus.ram_wren  <= state == WAIT && bus.rom_data_ready;
      bus.init_done <= state == WRITE && last;
      if (start) begin
        state           <= READ;
        cnt             <= '0;
        bus.rom_address <= ADDR_W'(ROM_BASE);
        bus.ram_address <= ADDR_W'(RAM_BASE);
        bus.init_busy   <= 1'b1;
`ifdef ROM2RAM_CSUM_EN
        bus.checksum    <= '0;
`endif
      end else
        case (state)
          READ: state <= WAIT;
          WAIT:
            if (bus.rom_data_ready) begin
              state       <= WRITE;
              bus.dataout <= bus.datain;
`ifdef ROM2RAM_CSUM_EN
              bus.checksum <= bus.checksum + bus.datain;
`endif
            end
          WRITE:
            if (last) begin
              state         <= DONE;
              bus.init_busy <= 1'b0;
            end else begin
              state           <= READ;
              cnt             <= cnt + 1'b1;
              bus.rom_address <= bus.rom_address + 1'b1;
              bus.ram_address <= bus.ram_address + 1'b1;
            end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_rom2ram_loader.sv
// tb_rom2ram_loader: randomized-latency scoreboard bench for rom2ram_loader (main instance plus a 4-bit wrap instance)
module tb_rom2ram_loader;
  localparam int AW = 10;
  localparam int NW = 4;
  localparam int RB = 16;
  localparam int WB = 512;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  rom2ram_if #(.DATA_W(8), .ADDR_W(AW)) a();
  rom2ram_if #(.DATA_W(8), .ADDR_W(4))  b();
  rom2ram_loader #(.DATA_W(8), .ADDR_W(AW), .WORDS(NW), .ROM_BASE(RB), .RAM_BASE(WB))
    dut (.clock(clk), .reset(rst), .bus(a));
  rom2ram_loader #(.DATA_W(8), .ADDR_W(4), .WORDS(3), .ROM_BASE(14), .RAM_BASE(15))
    dut_b (.clock(clk), .reset(rst), .bus(b));

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [0:1023];
  logic [7:0] ram [0:1023];
  logic [AW-1:0] rom_q[$];
  logic [AW+7:0] wr_q[$];
  logic [7:0] csum_q[$];
  logic [AW-1:0] rd_addr;
  int lat_max = 1;
  bit got_ready = 0;
  bit resp_busy = 0;
  bit b_done = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // expected stream of one copy, derived from base addresses and ROM contents
  task automatic push_copy();
    logic [7:0] s;
    s = 0;
    for (int i = 0; i < NW; i++) begin
      rom_q.push_back(AW'(RB + i));
      wr_q.push_back({AW'(WB + i), mem[(RB + i) % 1024]});
      s += mem[(RB + i) % 1024];
    end
    csum_q.push_back(s);
  endtask

  task automatic start_copy();
    push_copy();
    @(posedge clk); #1 a.init = 1;
    @(posedge clk); #1 a.init = 0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0;
    nb = 0;
    forever begin
      @(negedge clk);
      if (a.init_done === 1 || n >= 1000) break;
      n++;
      if (a.init_busy === 1) nb++;
    end
    chk("init_done_seen", 32'(a.init_done), 1);
  endtask

  // ROM model: answers each rden after 1..lat_max cycles
  initial begin
    a.rom_data_ready = 0;
    a.datain = 0;
    forever begin
      @(negedge clk);
      if (a.rom_rden === 1) begin
        rd_addr = a.rom_address;
        resp_busy = 1;
        if (rom_q.size() == 0) chk("rom_extra_rden", 32'(rom_q.size()), 1);
        else chk("rom_addr", 32'(rd_addr), 32'(rom_q.pop_front()));
        repeat ($urandom_range(lat_max, 1)) @(posedge clk);
        #1 a.rom_data_ready = 1; a.datain = mem[rd_addr]; got_ready = 1;
        @(posedge clk);
        #1 a.rom_data_ready = 0; a.datain = 8'($urandom); resp_busy = 0;
      end
    end
  end

  // scoreboard monitor for RAM writes and completion
  initial begin
    logic [AW+7:0] e;
    forever begin
      @(negedge clk);
      if (a.ram_wren === 1) begin
        chk("wren_after_ready", 32'(got_ready), 1);
        got_ready = 0;
        wr_cnt++;
        ram[a.ram_address] = a.dataout;
        if (wr_q.size() == 0) chk("ram_extra_wren", 32'(wr_q.size()), 1);
        else begin
          e = wr_q.pop_front();
          chk("ram_addr", 32'(a.ram_address), 32'(e[AW+7:8]));
          chk("ram_data", 32'(a.dataout), 32'(e[7:0]));
        end
      end
      if (a.init_done === 1) begin
        chk("words_per_copy", 32'(wr_cnt), NW);
        wr_cnt = 0;
`ifdef ROM2RAM_CSUM_EN
        if (csum_q.size() != 0) chk("checksum", 32'(a.checksum), 32'(csum_q.pop_front()));
`endif
      end
    end
  end

  // second instance: address wrap in a 4-bit space
  initial begin
    logic [3:0] brom [3];
    logic [3:0] bram [3];
    int bi, bw;
    brom = '{4'hE, 4'hF, 4'h0};
    bram = '{4'hF, 4'h0, 4'h1};
    bi = 0;
    bw = 0;
    b.init = 0;
    b.rom_data_ready = 0;
    b.datain = 0;
    wait (rst == 0);
    @(posedge clk); #1 b.init = 1;
    @(posedge clk); #1 b.init = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (b.init_done === 1) break;
      if (b.ram_wren === 1) begin
        if (bw < 3) begin
          chk("b_ram_addr", 32'(b.ram_address), 32'(bram[bw]));
          chk("b_ram_data", 32'(b.dataout), 32'({4'h0, brom[bw]} ^ 8'hA5));
        end else chk("b_wren_count", bw + 1, 3);
        bw++;
      end
      if (b.rom_rden === 1) begin
        if (bi < 3) chk("b_rom_addr", 32'(b.rom_address), 32'(brom[bi]));
        else chk("b_rden_count", bi + 1, 3);
        bi++;
        @(posedge clk); #1 b.rom_data_ready = 1; b.datain = {4'h0, b.rom_address} ^ 8'hA5;
        @(posedge clk); #1 b.rom_data_ready = 0;
      end
    end
    chk("b_done", 32'(b.init_done), 1);
    chk("b_reads", bi, 3);
    chk("b_writes", bw, 3);
    b_done = 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int n, nb;
    logic [7:0] t1v [4];
    t1v = '{8'h4A, 8'h4B, 8'h48, 8'h49};
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h5A;
    a.init = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_address", 32'(a.rom_address), 0);
    chk("rst_ram_address", 32'(a.ram_address), 0);
    chk("rst_dataout", 32'(a.dataout), 0);
    chk("rst_strobes", {30'd0, a.rom_rden, a.ram_wren}, 0);
    chk("rst_busy_done", {30'd0, a.init_busy, a.init_done}, 0);
`ifdef ROM2RAM_CSUM_EN
    chk("rst_checksum", 32'(a.checksum), 0);
`endif
    rst = 0;
    // fixed one-cycle ROM latency: timing and known data
    start_copy();
    wait_done(n, nb);
    chk("t1_cycles", n, 12);
    chk("t1_busy_cycles", nb, 12);
    chk("t1_busy_at_done", 32'(a.init_busy), 0);
    for (int i = 0; i < 4; i++) chk("t1_ram", 32'(ram[WB + i]), 32'(t1v[i]));
    // random latency and random ROM content, 16 words over four copies
    lat_max = 7;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      start_copy();
      wait_done(n, nb);
    end
    // checksum wrap case
    lat_max = 1;
    mem[RB] = 8'hF0; mem[RB+1] = 8'h20; mem[RB+2] = 8'h05; mem[RB+3] = 8'h00;
    start_copy();
    wait_done(n, nb);
`ifdef ROM2RAM_CSUM_EN
    chk("t6_checksum", 32'(a.checksum), 8'h15);
    repeat (3) @(negedge clk);
    chk("t6_checksum_hold", 32'(a.checksum), 8'h15);
`endif
    // init pulse while busy is ignored; held init restarts right after DONE
    lat_max = 4;
    push_copy();
    push_copy();
    @(posedge clk); #1 a.init = 1;
    @(posedge clk); #1 a.init = 0;
    for (int c = 0; c < 100 && a.ram_wren !== 1; c++) @(negedge clk);
    a.init = 1;
    @(posedge clk); #1 a.init = 0;
    @(posedge clk); #1 a.init = 1;
    wait_done(n, nb);
    @(posedge clk); #1 a.init = 0;
    @(negedge clk);
    chk("t5_restart_rden", 32'(a.rom_rden), 1);
    chk("t5_restart_busy", 32'(a.init_busy), 1);
    wait_done(n, nb);
    // reset during WAIT of the second word aborts the copy
    lat_max = 7;
    start_copy();
    for (int c = 0; c < 100 && wr_cnt < 1; c++) @(negedge clk);
    for (int c = 0; c < 100 && a.rom_rden !== 1; c++) @(negedge clk);
    @(posedge clk); #2 rst = 1;
    #1;
    chk("t4_strobes", {30'd0, a.rom_rden, a.ram_wren}, 0);
    chk("t4_busy", 32'(a.init_busy), 0);
    chk("t4_rom_address", 32'(a.rom_address), 0);
    @(posedge clk); #1 rst = 0;
    for (int c = 0; c < 20 && resp_busy; c++) @(posedge clk);
    repeat (2) @(negedge clk);
    chk("t4_no_strobe_after", {30'd0, a.rom_rden, a.ram_wren}, 0);
    rom_q.delete();
    wr_q.delete();
    csum_q.delete();
    got_ready = 0;
    wr_cnt = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    start_copy();
    wait_done(n, nb);
    chk("t4_queues_drained", rom_q.size() + wr_q.size(), 0);
    for (int c = 0; c < 200 && !b_done; c++) @(posedge clk);
    chk("b_finished", 32'(b_done), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
